// File: rtl/riscv_csr_exec.sv
// CSR execution unit: read-modify-write sequencing in front of the CSR regfile.
// Optional RISCV_CSR_ILLEGAL_CHECK_EN adds resp_illegal and address legality checks.
module riscv_csr_exec #(
  parameter int          XLEN      = 32,
  parameter logic [11:0] NOP_WADDR = 12'h000
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [11:0]     req_addr,
  input  logic [XLEN-1:0] req_src,
  input  logic            req_src_zero,
  input  logic [4:0]      req_rd,
  input  logic            flush,
  output logic [11:0]     csr_raddr,
  input  logic [XLEN-1:0] csr_rdata,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [4:0]      resp_rd,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
`ifdef RISCV_CSR_ILLEGAL_CHECK_EN
  ,
  output logic            resp_illegal
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  state_t          state_q;
  state_t          state_d;
  logic [1:0]      op_q;
  logic [11:0]     addr_q;
  logic [XLEN-1:0] src_q;
  logic            src_zero_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] old_q;
  logic [XLEN-1:0] wval_q;
  logic [XLEN-1:0] wval;
  logic            is_set;
  logic            is_clr;
  logic            we;
  logic            accept;
  logic            illegal;

  assign is_set = (op_q == OP_RS);
  assign is_clr = (op_q == OP_RC);
  assign accept = req_valid && req_ready && !flush;

  // RS/RC with a zero source are pure reads
  assign we = !((is_set || is_clr) && src_zero_q);

  always_comb begin
    wval = src_q;
    unique case (1'b1)
      is_set:  wval = csr_rdata | src_q;
      is_clr:  wval = csr_rdata & ~src_q;
      default: wval = src_q;
    endcase
  end

`ifdef RISCV_CSR_ILLEGAL_CHECK_EN
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MTIME    = 12'hC01;
  localparam logic [11:0] CSR_MTIMEH   = 12'hC81;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  logic known;
  logic illegal_q;

  always_comb begin
    known = 1'b0;
    case (addr_q)
      CSR_MSTATUS, CSR_MISA, CSR_MIE,
      CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
      CSR_MCAUSE, CSR_MTVAL, CSR_MIP,
      CSR_MCYCLE, CSR_MTIME, CSR_MTIMEH,
      CSR_MHARTID: known = 1'b1;
      default:     known = 1'b0;
    endcase
  end

  assign illegal = !known ||
                   (we && (addr_q[11:10] == 2'b11));

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      illegal_q <= 1'b0;
    end else if (state_q == READ) begin
      illegal_q <= illegal;
    end
  end

  assign resp_illegal = (state_q == RESP) && illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = READ;
      end
      READ: begin
        if (flush)        state_d = IDLE;
        else if (illegal) state_d = RESP;
        else if (we)      state_d = WRITE;
        else              state_d = RESP;
      end
      // the write commits even when flushed here
      WRITE: begin
        if (flush) state_d = IDLE;
        else       state_d = RESP;
      end
      RESP: begin
        if (flush || resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      op_q       <= '0;
      addr_q     <= '0;
      src_q      <= '0;
      src_zero_q <= 1'b0;
      rd_q       <= '0;
    end else if (accept) begin
      op_q       <= req_op;
      addr_q     <= req_addr;
      src_q      <= req_src;
      src_zero_q <= req_src_zero;
      rd_q       <= req_rd;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      old_q  <= '0;
      wval_q <= '0;
    end else if (state_q == READ) begin
      old_q  <= illegal ? '0 : csr_rdata;
      wval_q <= wval;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign csr_raddr  = (state_q == READ) ? addr_q : '0;
  assign csr_waddr  = (state_q == WRITE) ? addr_q : NOP_WADDR;
  assign csr_wdata  = (state_q == WRITE) ? wval_q : '0;
  assign resp_valid = (state_q == RESP);
  assign resp_rd    = (state_q == RESP) ? rd_q : '0;
  assign resp_data  = (state_q == RESP) ? old_q : '0;

endmodule

// File: tb/tb_riscv_csr_exec.sv
// Bench for riscv_csr_exec: table vectors, corner sequences, random ops
// against a behavioural CSR model.
module tb_riscv_csr_exec;

  localparam int          XLEN   = 32;
  localparam logic [11:0] NOP    = 12'h000;
  localparam logic [31:0] CPU_ID = 32'h0000_0007;

  logic            clk;
  logic            arst;
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [11:0]     req_addr;
  logic [XLEN-1:0] req_src;
  logic            req_src_zero;
  logic [4:0]      req_rd;
  logic            flush;
  logic [11:0]     csr_raddr;
  logic [XLEN-1:0] csr_rdata;
  logic [11:0]     csr_waddr;
  logic [XLEN-1:0] csr_wdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [4:0]      resp_rd;
  logic [XLEN-1:0] resp_data;
  logic            busy;
`ifdef RISCV_CSR_ILLEGAL_CHECK_EN
  logic            resp_illegal;
`endif

  riscv_csr_exec #(.XLEN(XLEN), .NOP_WADDR(NOP)) dut (
    .clk          (clk),
    .arst         (arst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_src      (req_src),
    .req_src_zero (req_src_zero),
    .req_rd       (req_rd),
    .flush        (flush),
    .csr_raddr    (csr_raddr),
    .csr_rdata    (csr_rdata),
    .csr_waddr    (csr_waddr),
    .csr_wdata    (csr_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rd      (resp_rd),
    .resp_data    (resp_data),
    .busy         (busy)
`ifdef RISCV_CSR_ILLEGAL_CHECK_EN
    ,
    .resp_illegal (resp_illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [11:0] a);
    case (a)
      12'h300: return 32'h0000_1800;
      12'h301: return 32'h4000_1100;
      12'hC01: return 32'h1234_5678;
      12'hF14: return CPU_ID;
      default: return 32'h0;
    endcase
  endfunction

  // CSR register file environment: read-only space ignores writes
  logic [31:0] mem [4096];
  logic        preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_val(12'(i));
    end else if (csr_waddr != NOP && csr_waddr[11:10] != 2'b11) begin
      mem[csr_waddr] <= csr_wdata;
    end
  end
  assign csr_rdata = mem[csr_raddr];

  logic [31:0] ref_mem [4096];
  int total;
  int pass_cnt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic model_illegal(input logic [11:0] a,
                                         input logic w);
`ifdef RISCV_CSR_ILLEGAL_CHECK_EN
    logic [11:0] legal [13] = '{12'h300, 12'h301, 12'h304, 12'h305,
      12'h340, 12'h341, 12'h342, 12'h343, 12'h344, 12'hB00,
      12'hC01, 12'hC81, 12'hF14};
    logic found = 1'b0;
    foreach (legal[i]) if (legal[i] == a) found = 1'b1;
    return !found || (w && a[11:10] == 2'b11);
`else
    return 1'b0;
`endif
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [11:0] addr,
                        input logic [31:0] src, input logic sz,
                        input logic [4:0] rd, input int hold,
                        input logic [31:0] exp_old, input logic exp_we,
                        input logic [31:0] exp_wd, input logic exp_ill,
                        input string nm);
    int n;
    int wr_cnt;
    int wr_n;
    logic [11:0] wa;
    logic [31:0] wd;
    logic got;
    logic [31:0] exp_data;
    exp_data = exp_ill ? 32'h0 : exp_old;
    chk({nm, " req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_addr = addr;
    req_src = src; req_src_zero = sz; req_rd = rd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_op = 2'b00; req_src = '0;
    n = 1; wr_cnt = 0; wr_n = 0; got = 1'b0; wa = '0; wd = '0;
    while (n <= 8 && !got) begin
      if (csr_waddr != NOP) begin
        wr_cnt++; wr_n = n; wa = csr_waddr; wd = csr_wdata;
      end
      if (resp_valid) got = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk({nm, " latency"}, 32'(n), exp_we ? 32'd3 : 32'd2);
    chk({nm, " writes"}, 32'(wr_cnt), exp_we ? 32'd1 : 32'd0);
    if (exp_we) begin
      chk({nm, " waddr"}, 32'(wa), 32'(addr));
      chk({nm, " wdata"}, wd, exp_wd);
      chk({nm, " wcycle"}, 32'(wr_n), 32'd2);
    end
    chk({nm, " resp_rd"}, 32'(resp_rd), 32'(rd));
    chk({nm, " resp_data"}, resp_data, exp_data);
`ifdef RISCV_CSR_ILLEGAL_CHECK_EN
    chk({nm, " resp_illegal"}, 32'(resp_illegal), 32'(exp_ill));
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, " hold valid"}, 32'(resp_valid), 32'd1);
      chk({nm, " hold rd"}, 32'(resp_rd), 32'(rd));
      chk({nm, " hold data"}, resp_data, exp_data);
      chk({nm, " hold ready"}, 32'(req_ready), 32'd0);
      chk({nm, " hold busy"}, 32'(busy), 32'd1);
      chk({nm, " hold waddr"}, 32'(csr_waddr), 32'(NOP));
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({nm, " idle ready"}, 32'(req_ready), 32'd1);
    chk({nm, " idle valid"}, 32'(resp_valid), 32'd0);
    if (exp_we && addr[11:10] != 2'b11) ref_mem[addr] = exp_wd;
    chk({nm, " regfile"}, mem[addr], ref_mem[addr]);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] src;
    logic        sz;
    logic [4:0]  rd;
    int          hold;
    logic [31:0] exp_old;
    logic        exp_we;
    logic [31:0] exp_wd;
    logic        exp_ill;
  } vec_t;

  vec_t vt [9];
  logic [11:0] pool [11] = '{12'h300, 12'h301, 12'h304, 12'h305,
    12'h340, 12'h341, 12'h342, 12'h344, 12'hC01, 12'hF14, 12'h7C0};

  initial begin
    logic        noresp;
    logic [1:0]  op;
    logic [11:0] a;
    logic [31:0] s;
    logic [31:0] old;
    logic [31:0] nv;
    logic        sz;
    logic        w;
    logic        ill;

    total = 0; pass_cnt = 0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));

    vt[0] = '{2'b01, 12'h340, 32'hDEAD_BEEF, 1'b0, 5'd5, 0,
              32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vt[1] = '{2'b10, 12'h340, 32'h0, 1'b1, 5'd6, 0,
              32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0};
    vt[2] = '{2'b10, 12'h300, 32'h8, 1'b0, 5'd7, 4,
              32'h1800, 1'b1, 32'h1808, 1'b0};
    vt[3] = '{2'b11, 12'h300, 32'h800, 1'b0, 5'd8, 0,
              32'h1808, 1'b1, 32'h1008, 1'b0};
    vt[4] = '{2'b10, 12'hF14, 32'h0, 1'b1, 5'd9, 0,
              CPU_ID, 1'b0, 32'h0, 1'b0};
    vt[5] = '{2'b00, 12'h305, 32'h100, 1'b0, 5'd10, 1,
              32'h0, 1'b1, 32'h100, 1'b0};
`ifdef RISCV_CSR_ILLEGAL_CHECK_EN
    vt[6] = '{2'b01, 12'hF14, 32'h1, 1'b0, 5'd11, 0,
              CPU_ID, 1'b0, 32'h0, 1'b1};
    vt[7] = '{2'b10, 12'h7C0, 32'h0, 1'b1, 5'd12, 0,
              32'h0, 1'b0, 32'h0, 1'b1};
`else
    vt[6] = '{2'b01, 12'hF14, 32'h1, 1'b0, 5'd11, 0,
              CPU_ID, 1'b1, 32'h1, 1'b0};
    vt[7] = '{2'b10, 12'h7C0, 32'h0, 1'b1, 5'd12, 0,
              32'h0, 1'b0, 32'h0, 1'b0};
`endif
    vt[8] = '{2'b11, 12'h301, 32'hFFFF_FFFF, 1'b0, 5'd13, 0,
              32'h4000_1100, 1'b1, 32'h0, 1'b0};

    arst = 1'b1; preload = 1'b1; flush = 1'b0;
    req_valid = 1'b0; req_op = '0; req_addr = '0; req_src = '0;
    req_src_zero = 1'b0; req_rd = '0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    arst = 1'b0;
    @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_rd", 32'(resp_rd), 32'd0);
    chk("rst resp_data", resp_data, 32'd0);
    chk("rst raddr", 32'(csr_raddr), 32'd0);
    chk("rst waddr", 32'(csr_waddr), 32'(NOP));
    chk("rst wdata", csr_wdata, 32'd0);

    foreach (vt[i])
      run_op(vt[i].op, vt[i].addr, vt[i].src, vt[i].sz, vt[i].rd,
             vt[i].hold, vt[i].exp_old, vt[i].exp_we, vt[i].exp_wd,
             vt[i].exp_ill, $sformatf("vec%0d", i));

    // flush in READ: no write, no response
    req_valid = 1'b1; req_op = 2'b01; req_addr = 12'h305;
    req_src = 32'hAAAA_0000; req_src_zero = 1'b0; req_rd = 5'd3;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    chk("flrd raddr", 32'(csr_raddr), 32'h305);
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    chk("flrd busy", 32'(busy), 32'd0);
    noresp = 1'b1;
    repeat (3) begin
      if (resp_valid || csr_waddr != NOP) noresp = 1'b0;
      @(negedge clk);
    end
    chk("flrd quiet", 32'(noresp), 32'd1);
    chk("flrd mtvec", mem[12'h305], 32'h100);

    // flush in WRITE: write commits, no response
    req_valid = 1'b1; req_src = 32'h5555;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("flwr waddr", 32'(csr_waddr), 32'h305);
    chk("flwr wdata", csr_wdata, 32'h5555);
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    ref_mem[12'h305] = 32'h5555;
    chk("flwr busy", 32'(busy), 32'd0);
    noresp = 1'b1;
    repeat (3) begin
      if (resp_valid) noresp = 1'b0;
      @(negedge clk);
    end
    chk("flwr quiet", 32'(noresp), 32'd1);
    chk("flwr mtvec", mem[12'h305], 32'h5555);

    // flush in RESP drops the response
    req_valid = 1'b1; req_op = 2'b10; req_addr = 12'h300;
    req_src = 32'h0; req_src_zero = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("flrs valid", 32'(resp_valid), 32'd1);
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    chk("flrs dropped", 32'(resp_valid), 32'd0);
    chk("flrs ready", 32'(req_ready), 32'd1);

    // request coinciding with flush is ignored
    req_valid = 1'b1; flush = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    chk("flreq busy", 32'(busy), 32'd0);

    // async reset in WRITE
    req_valid = 1'b1; req_op = 2'b01; req_addr = 12'h340;
    req_src = 32'h1111; req_src_zero = 1'b0;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstwr waddr", 32'(csr_waddr), 32'h340);
    #1 arst = 1'b1;
    #1;
    chk("rstwr waddr0", 32'(csr_waddr), 32'(NOP));
    chk("rstwr wdata0", csr_wdata, 32'd0);
    chk("rstwr busy", 32'(busy), 32'd0);
    chk("rstwr ready", 32'(req_ready), 32'd1);
    chk("rstwr valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    chk("rstwr mscratch", mem[12'h340], ref_mem[12'h340]);

    for (int k = 0; k < 60; k++) begin
      a  = pool[$urandom_range(0, 10)];
      op = 2'($urandom_range(0, 3));
      sz = ($urandom_range(0, 3) == 0);
      s  = sz ? 32'h0 : $urandom;
      old = ref_mem[a];
      case (op)
        2'b10:   nv = old | s;
        2'b11:   nv = old & ~s;
        default: nv = s;
      endcase
      w = !(op[1] && sz);
      ill = model_illegal(a, w);
      if (ill) w = 1'b0;
      run_op(op, a, s, sz, 5'($urandom_range(0, 31)),
             int'($urandom_range(0, 2)), old, w, nv, ill,
             $sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
